// File: rtl/obstacle_column_gen.sv
// Emits one obstacle column per frame tick: SPACING clear columns, then a
// PIPE_WIDTH-wide pipe with a pseudo-random GAP_ROWS-high gap, repeating.
module obstacle_column_gen #(
    parameter int          ROWS       = 30,
    parameter int          GAP_ROWS   = 8,
    parameter int          PIPE_WIDTH = 3,
    parameter int          SPACING    = 10,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            tick,
    output logic [ROWS-1:0] column,
    output logic            column_valid,
    output logic            pipe_active,
    output logic [4:0]      gap_top
);

    localparam int          GAP_SPAN = ROWS - GAP_ROWS - 1;
    localparam int          SW       = $clog2(SPACING + 1);
    localparam int          WW       = $clog2(PIPE_WIDTH + 1);
    localparam logic [15:0] TAPS     = 16'hB400;

    typedef enum logic {SPACE, PIPE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   space_q, space_d;
    logic [WW-1:0]   width_q, width_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [ROWS-1:0] col_q, col_d;
    logic            valid_q, valid_d;
    logic            pipe_q, pipe_d;
    logic [4:0]      gap_q, gap_d;

    logic            first_pipe;
    logic [4:0]      raw;
    logic [4:0]      gap_new;
    logic [4:0]      gap_sel;
    logic [7:0]      gap_lo;
    logic [7:0]      gap_hi;
    logic [15:0]     lfsr_step;
    logic [ROWS-1:0] pipe_col;

    // The gap is chosen from the LFSR value present before this tick's advance.
    assign first_pipe = (state_q == PIPE) && (width_q == WW'(PIPE_WIDTH));
    assign raw        = lfsr_q[4:0];
    assign gap_new    = (raw < 5'(GAP_SPAN)) ? raw + 5'd1 : raw - 5'(GAP_SPAN - 1);
    assign gap_sel    = first_pipe ? gap_new : gap_q;
    assign gap_lo     = {3'b000, gap_sel};
    assign gap_hi     = gap_lo + 8'(GAP_ROWS - 1);
    assign lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign pipe_col[gi] = !((8'(gi) >= gap_lo) && (8'(gi) <= gap_hi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        space_d = space_q;
        width_d = width_q;
        lfsr_d  = lfsr_q;
        col_d   = col_q;
        pipe_d  = pipe_q;
        gap_d   = gap_q;
        valid_d = 1'b0;
        if (tick) begin
            valid_d = 1'b1;
            lfsr_d  = (lfsr_q == 16'h0000) ? SEED : lfsr_step;
            case (state_q)
                SPACE: begin
                    col_d   = '0;
                    pipe_d  = 1'b0;
                    space_d = space_q - SW'(1);
                    if (space_q == SW'(1)) begin
                        state_d = PIPE;
                        width_d = WW'(PIPE_WIDTH);
                    end
                end
                PIPE: begin
                    gap_d   = gap_sel;
                    col_d   = pipe_col;
                    pipe_d  = 1'b1;
                    width_d = width_q - WW'(1);
                    if (width_q == WW'(1)) begin
                        state_d = SPACE;
                        space_d = SW'(SPACING);
                    end
                end
                default: state_d = SPACE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SPACE;
            space_q <= SW'(SPACING);
            width_q <= '0;
            lfsr_q  <= SEED;
            col_q   <= '0;
            valid_q <= 1'b0;
            pipe_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            space_q <= space_d;
            width_q <= width_d;
            lfsr_q  <= lfsr_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            pipe_q  <= pipe_d;
            gap_q   <= gap_d;
        end
    end

    assign column       = col_q;
    assign column_valid = valid_q;
    assign pipe_active  = pipe_q;
    assign gap_top      = gap_q;

endmodule

// File: tb/tb_obstacle_column_gen.sv
// Scoreboard bench: four generators (default seed plus three boundary seeds)
// run in lockstep against a period/position reference model.
module tb_obstacle_column_gen;

    localparam int ROWS = 30;
    localparam int GAPR = 8;
    localparam int PW   = 3;
    localparam int SP   = 10;
    localparam int NI   = 4;

    // Walks the LFSR backwards so a chosen state is reached after n advances.
    function automatic logic [15:0] lfsr_back(input logic [15:0] v, input int n);
        logic [15:0] p;
        p = v;
        for (int i = 0; i < n; i++)
            p = p[15] ? (((p ^ 16'hB400) << 1) | 16'h0001) : (p << 1);
        return p;
    endfunction

    localparam logic [15:0] SEEDS [NI] = '{16'hACE1,
                                           lfsr_back(16'h1234, SP),
                                           lfsr_back(16'h1235, SP),
                                           lfsr_back(16'h123F, SP)};

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 tick;
    logic [NI-1:0][ROWS-1:0] col_w;
    logic [NI-1:0]        valid_w;
    logic [NI-1:0]        pa_w;
    logic [NI-1:0][4:0]   gap_w;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            obstacle_column_gen #(
                .ROWS(ROWS), .GAP_ROWS(GAPR), .PIPE_WIDTH(PW),
                .SPACING(SP), .SEED(SEEDS[gi])
            ) u_dut (
                .clk          (clk),
                .resetn       (resetn),
                .tick         (tick),
                .column       (col_w[gi]),
                .column_valid (valid_w[gi]),
                .pipe_active  (pa_w[gi]),
                .gap_top      (gap_w[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [NI-1:0][ROWS-1:0] col;
        logic [NI-1:0][4:0]      gap;
        logic [NI-1:0]           pa;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   strobe_cnt = 0;
    int   txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    function automatic logic [15:0] lfsr_fwd(input logic [15:0] v, input logic [15:0] seed);
        if (v == 16'h0000) return seed;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model: position within the SP+PW period decides clear vs pipe.
    initial begin : model
        int          cnt [NI];
        logic [15:0] lf  [NI];
        int          gap [NI];
        exp_t        e;
        int          pos, r;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                for (int k = 0; k < NI; k++) begin
                    cnt[k] = 0; lf[k] = SEEDS[k]; gap[k] = 0;
                end
                exp_q.delete();
            end else if (tick) begin
                e = '0;
                for (int k = 0; k < NI; k++) begin
                    cnt[k]++;
                    pos = ((cnt[k] - 1) % (SP + PW)) + 1;
                    if (pos == SP + 1) begin
                        r = int'(lf[k][4:0]);
                        if (r >= ROWS - GAPR - 1) r -= ROWS - GAPR - 1;
                        gap[k] = r + 1;
                    end
                    if (pos > SP) begin
                        for (int i = 0; i < ROWS; i++)
                            e.col[k][i] = !(i >= gap[k] && i <= gap[k] + GAPR - 1);
                        e.pa[k] = 1'b1;
                    end
                    e.gap[k] = 5'(gap[k]);
                    lf[k] = lfsr_fwd(lf[k], SEEDS[k]);
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: every strobe pops one expected column; a missing strobe is flagged.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid_w != '0) begin
                strobe_cnt++;
                chk("valid_all", 32'(valid_w), 32'hF);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: col=%h gap=%0d pipe=%0b", txn, col_w[0], gap_w[0], pa_w[0]);
                    for (int k = 0; k < NI; k++) begin
                        chk($sformatf("col[%0d]", k), 32'(col_w[k]), 32'(e.col[k]));
                        chk($sformatf("gap[%0d]", k), 32'(gap_w[k]), 32'(e.gap[k]));
                        chk($sformatf("pa[%0d]", k), 32'(pa_w[k]), 32'(e.pa[k]));
                    end
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_strobe", 32'(valid_w), 32'hF);
                exp_q.delete();
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_col[%0d]", tag, k), 32'(col_w[k]), 32'h0);
            chk($sformatf("%s_gap[%0d]", tag, k), 32'(gap_w[k]), 32'h0);
            chk($sformatf("%s_pa_valid[%0d]", tag, k), {30'h0, pa_w[k], valid_w[k]}, 32'h0);
        end
    endtask

    initial begin : stim
        int   s0;
        logic hold_bad;
        logic [ROWS-1:0] c_snap;
        logic [4:0]      g_snap;
        logic            p_snap;

        resetn = 1'b0;
        tick   = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        resetn = 1'b1;

        tick_n(SP + 1);
        chk("first_pipe_col", 32'(col_w[0]), 32'h3C03FFFF);
        chk("first_pipe_gap", 32'(gap_w[0]), 32'd18);
        chk("b20_gap", 32'(gap_w[1]), 32'd21);
        chk("b20_col", 32'(col_w[1]), 32'h201FFFFF);
        chk("b21_gap", 32'(gap_w[2]), 32'd1);
        chk("b21_col", 32'(col_w[2]), 32'h3FFFFE01);
        chk("b31_gap", 32'(gap_w[3]), 32'd11);
        chk("b31_col", 32'(col_w[3]), 32'h3FF807FF);

        tick_n(1);
        #2 resetn = 1'b0;
        #1 chk_zero("midpipe_reset");
        @(negedge clk);
        resetn = 1'b1;

        tick_n(SP + 1);
        chk("repipe_col", 32'(col_w[0]), 32'h3C03FFFF);
        chk("repipe_gap", 32'(gap_w[0]), 32'd18);
        tick_n(13);
        chk("tick24_pipe", 32'(pa_w[0]), 32'd1);

        s0 = strobe_cnt;
        tick_n(5);
        chk("burst_strobes", 32'(strobe_cnt - s0), 32'd5);

        s0 = strobe_cnt;
        hold_bad = 1'b0;
        c_snap = col_w[0]; g_snap = gap_w[0]; p_snap = pa_w[0];
        repeat (1000) begin
            @(negedge clk);
            if (col_w[0] !== c_snap || gap_w[0] !== g_snap || pa_w[0] !== p_snap || valid_w[0] !== 1'b0)
                hold_bad = 1'b1;
        end
        chk("idle_hold", 32'(hold_bad), 32'd0);
        chk("idle_strobes", 32'(strobe_cnt - s0), 32'd0);

        repeat (400) begin
            @(negedge clk);
            tick = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
